// File: rtl/axil_cmd_master_if.sv
// axil_cmd_master_if: AXI-Lite signal bundle between the command master and an OCL-style slave
// Ports (signals): AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready).
// Modports: master drives valids/payloads and bready/rready; slave drives the rest.
interface axil_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI-Lite initiator driven by a command/response stream
// Ports:
//   clk_main_a0, rst_main_n        clock, asynchronous active-low reset
//   i_cmd_* / o_cmd_ready          command stream (write flag, address, data, strobes)
//   o_rsp_* / i_rsp_ready          response stream (write echo, read data, resp, timeout flag)
//   m_axi                          AXI-Lite master port (axil_cmd_master_if.master)
//   o_wr_count, o_rd_count         completed writes/reads, wrapping
//   o_err_count                    completed transactions with nonzero resp, saturating
module axil_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_wdata,
  input  logic [DATA_W/8-1:0] i_cmd_wstrb,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic                o_rsp_write,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic [1:0]          o_rsp_resp,
  output logic                o_rsp_timeout,
  axil_cmd_master_if.master   m_axi,
  output logic [31:0]         o_wr_count,
  output logic [31:0]         o_rd_count,
  output logic [15:0]         o_err_count
);
  localparam int PW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_rsp_valid;
  logic                r_write;
  logic                r_timeout;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_resp;
  logic [PW-1:0]       r_phase;
  logic [31:0]         r_wr_count;
  logic [31:0]         r_rd_count;
  logic [15:0]         r_err_count;
  logic                w_wait;
  logic                w_aw_done;
  logic                w_w_done;
  assign w_wait    = r_state inside {WR, WR_RESP, RD_ADDR, RD_DATA};
  // A write channel is finished when its beat was already taken or is being taken now.
  assign w_aw_done = !r_awvalid || m_axi.awready;
  assign w_w_done  = !r_wvalid || m_axi.wready;
  assign o_cmd_ready   = r_cmd_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_write   = r_write;
  assign o_rsp_rdata   = r_rdata;
  assign o_rsp_resp    = r_resp;
  assign o_rsp_timeout = r_timeout;
  assign o_wr_count    = r_wr_count;
  assign o_rd_count    = r_rd_count;
  assign o_err_count   = r_err_count;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_write     <= 1'b0;
      r_timeout   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_resp      <= '0;
      r_phase     <= '0;
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_err_count <= '0;
    end else begin
      // Phase counter parks at TIMEOUT; the flag is sticky for the transaction while AXI keeps waiting.
      if (w_wait && r_phase != PW'(TIMEOUT)) r_phase <= r_phase + PW'(1);
      if (w_wait && r_phase == PW'(TIMEOUT)) r_timeout <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_cmd_ready && i_cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_write     <= i_cmd_write;
            r_addr      <= i_cmd_addr;
            r_wdata     <= i_cmd_wdata;
            r_wstrb     <= i_cmd_wstrb;
            r_timeout   <= 1'b0;
            r_phase     <= '0;
            r_awvalid   <= i_cmd_write;
            r_wvalid    <= i_cmd_write;
            r_arvalid   <= !i_cmd_write;
            r_state     <= i_cmd_write ? WR : RD_ADDR;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        WR: begin
          if (m_axi.awready) r_awvalid <= 1'b0;
          if (m_axi.wready) r_wvalid <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_phase  <= '0;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            r_bready <= 1'b0;
            r_resp   <= m_axi.bresp;
            r_rdata  <= '0;
            r_state  <= RSP;
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_phase   <= '0;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= m_axi.rdata;
            r_resp   <= m_axi.rresp;
            r_state  <= RSP;
          end
        end
        RSP: begin
          // First RSP cycle folds the captured resp into the counters so they change together with rsp_valid.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            if (r_write) r_wr_count <= r_wr_count + 32'd1;
            else r_rd_count <= r_rd_count + 32'd1;
            if (r_resp != 2'b00 && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed self-checking bench for axil_cmd_master with a cycle-stepped AXI-Lite slave
module tb_axil_cmd_master;
  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        i_cmd_write = 1'b0;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic [3:0]  i_cmd_wstrb = '0;
  logic        i_rsp_ready = 1'b0;
  logic        o_cmd_ready;
  logic        o_rsp_valid;
  logic        o_rsp_write;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic        o_rsp_timeout;
  logic [31:0] o_wr_count;
  logic [31:0] o_rd_count;
  logic [15:0] o_err_count;
  int checks = 0;
  int errors = 0;
  int lat, aw_beats, w_beats, b_beats, ar_beats, r_beats;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic drop, bready_early, w_low_aw_hi, unstable, cmd_ready_hi, done;
  logic        v_write, v_timeout;
  logic [31:0] v_rdata, v_wr, v_rd;
  logic [1:0]  v_resp;
  logic [15:0] v_err;
  logic [115:0] rsp_vec, snap;
  logic [222:0] all_out;

  always #5 clk_main_a0 = ~clk_main_a0;

  axil_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) m ();

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_main_a0(clk_main_a0),
    .rst_main_n(rst_main_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp),
    .o_rsp_timeout(o_rsp_timeout),
    .m_axi(m),
    .o_wr_count(o_wr_count),
    .o_rd_count(o_rd_count),
    .o_err_count(o_err_count)
  );

  assign rsp_vec = {o_rsp_write, o_rsp_rdata, o_rsp_resp, o_rsp_timeout, o_wr_count, o_rd_count, o_err_count};
  assign all_out = {o_cmd_ready, o_rsp_valid, rsp_vec, m.awaddr, m.awvalid, m.wdata, m.wstrb, m.wvalid,
                    m.bready, m.araddr, m.arvalid, m.rready};

  task automatic tick();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m.awready = 1'b0;
    m.wready  = 1'b0;
    m.bvalid  = 1'b0;
    m.bresp   = 2'b00;
    m.arready = 1'b0;
    m.rvalid  = 1'b0;
    m.rdata   = '0;
    m.rresp   = 2'b00;
  endtask

  // Issues one command and plays the slave: each ready rises dly cycles after its valid,
  // bvalid/rvalid rise dly cycles after the beats they depend on, rsp_ready after rsp_hold cycles.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly,
                         input int ar_dly, input int r_dly, input int rsp_hold,
                         input logic [1:0] resp, input logic [31:0] rdata);
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, hold;
    logic aw_pv, aw_pr, w_pv, w_pr, ar_pv, ar_pr, b_pend, b_started, r_pend, got;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; hold = 0;
    aw_pv = 0; aw_pr = 0; w_pv = 0; w_pr = 0; ar_pv = 0; ar_pr = 0;
    b_pend = 0; b_started = 0; r_pend = 0; got = 0;
    lat = 0; aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
    drop = 0; bready_early = 0; w_low_aw_hi = 0; unstable = 0; cmd_ready_hi = 0; done = 0;
    for (int k = 0; k < 20 && !o_cmd_ready; k++) tick();
    check("cmd_ready_before_issue", 64'(o_cmd_ready), 64'h1);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = data;
    i_cmd_wstrb = strb;
    tick();
    i_cmd_valid = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      if (o_cmd_ready) cmd_ready_hi = 1;
      if (aw_pv && !aw_pr && !m.awvalid) drop = 1;
      if (w_pv && !w_pr && !m.wvalid) drop = 1;
      if (ar_pv && !ar_pr && !m.arvalid) drop = 1;
      if (m.bready && !(aw_beats > 0 && w_beats > 0)) bready_early = 1;
      if (m.awvalid && !m.wvalid) w_low_aw_hi = 1;
      m.awready = m.awvalid && aw_cnt >= aw_dly;
      m.wready  = m.wvalid && w_cnt >= w_dly;
      m.arready = m.arvalid && ar_cnt >= ar_dly;
      m.bvalid  = b_pend && b_cnt >= b_dly;
      m.bresp   = m.bvalid ? resp : 2'b00;
      m.rvalid  = r_pend && r_cnt >= r_dly;
      m.rdata   = m.rvalid ? rdata : 32'h0;
      m.rresp   = m.rvalid ? resp : 2'b00;
      if (o_rsp_valid) begin
        if (!got) begin
          got = 1; lat = n; snap = rsp_vec;
          v_write = o_rsp_write; v_rdata = o_rsp_rdata; v_resp = o_rsp_resp; v_timeout = o_rsp_timeout;
          v_wr = o_wr_count; v_rd = o_rd_count; v_err = o_err_count;
        end else if (rsp_vec !== snap) unstable = 1;
        i_rsp_ready = hold >= rsp_hold;
        hold++;
      end else i_rsp_ready = 1'b0;
      if (m.awvalid && m.awready) begin aw_beats++; s_awaddr = m.awaddr; end
      if (m.wvalid && m.wready) begin w_beats++; s_wdata = m.wdata; s_wstrb = m.wstrb; end
      if (m.bvalid && m.bready) begin b_beats++; b_pend = 0; end
      if (m.rvalid && m.rready) begin r_beats++; r_pend = 0; end
      if (m.awvalid) aw_cnt++;
      if (m.wvalid) w_cnt++;
      if (m.arvalid) ar_cnt++;
      if (b_pend) b_cnt++;
      if (r_pend) r_cnt++;
      if (m.arvalid && m.arready) begin ar_beats++; s_araddr = m.araddr; r_pend = 1; r_cnt = 0; end
      if (aw_beats > 0 && w_beats > 0 && !b_started) begin b_started = 1; b_pend = 1; b_cnt = 0; end
      aw_pv = m.awvalid; aw_pr = m.awready;
      w_pv = m.wvalid; w_pr = m.wready;
      ar_pv = m.arvalid; ar_pr = m.arready;
      if (o_rsp_valid && i_rsp_ready) done = 1;
      tick();
    end
    check("txn_done", 64'(done), 64'h1);
    i_rsp_ready = 1'b0;
    slave_idle();
    check("cmd_ready_after_rsp", 64'(o_cmd_ready), 64'h1);
  endtask

  initial begin
    slave_idle();
    tick(); tick(); tick();
    check("reset_outputs_zero", 64'(|all_out), 64'h0);
    rst_main_n = 1'b1;
    check("cmd_ready_at_release", 64'(o_cmd_ready), 64'h0);
    tick();
    check("cmd_ready_after_release", 64'(o_cmd_ready), 64'h1);

    // Fastest write
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    check("t1_awaddr", 64'(s_awaddr), 64'h10);
    check("t1_wdata", 64'(s_wdata), 64'hDEADBEEF);
    check("t1_wstrb", 64'(s_wstrb), 64'hF);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_resp", 64'(v_resp), 64'h0);
    check("t1_rsp_write", 64'(v_write), 64'h1);
    check("t1_rsp_rdata", 64'(v_rdata), 64'h0);
    check("t1_wr_count", 64'(v_wr), 64'h1);
    check("t1_err_count", 64'(v_err), 64'h0);
    check("t1_beats", 64'({aw_beats[3:0], w_beats[3:0], b_beats[3:0]}), 64'h111);
    check("t1_cmd_ready_busy", 64'(cmd_ready_hi), 64'h0);

    // Read with arready 3 cycles late
    run_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 3, 0, 0, 2'b00, 32'h0000_0031);
    check("t2_araddr", 64'(s_araddr), 64'h24);
    check("t2_rsp_rdata", 64'(v_rdata), 64'h31);
    check("t2_rsp_write", 64'(v_write), 64'h0);
    check("t2_rd_count", 64'(v_rd), 64'h1);
    check("t2_latency", 64'(lat), 64'd7);
    check("t2_valid_held", 64'(drop), 64'h0);
    check("t2_timeout", 64'(v_timeout), 64'h0);

    // Write with W accepted 5 cycles before AW
    run_txn(1'b1, 32'h80, 32'h1234_5678, 4'h3, 5, 0, 0, 0, 0, 0, 2'b00, 32'h0);
    check("t3_w_low_aw_high", 64'(w_low_aw_hi), 64'h1);
    check("t3_valid_held", 64'(drop), 64'h0);
    check("t3_bready_early", 64'(bready_early), 64'h0);
    check("t3_beats", 64'({aw_beats[3:0], w_beats[3:0], b_beats[3:0]}), 64'h111);
    check("t3_awaddr", 64'(s_awaddr), 64'h80);
    check("t3_wstrb", 64'(s_wstrb), 64'h3);
    check("t3_latency", 64'(lat), 64'd9);
    check("t3_wr_count", 64'(v_wr), 64'h2);

    // Read with rvalid 20 cycles late: exceeds TIMEOUT=8
    run_txn(1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 20, 0, 2'b00, 32'h5A5A);
    check("t4_timeout", 64'(v_timeout), 64'h1);
    check("t4_resp", 64'(v_resp), 64'h0);
    check("t4_rdata", 64'(v_rdata), 64'h5A5A);
    check("t4_latency", 64'(lat), 64'd24);
    check("t4_rd_count", 64'(v_rd), 64'h2);

    // Error write response, rsp_ready held low for 10 cycles
    run_txn(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 10, 2'b10, 32'h0);
    check("t5_timeout_cleared", 64'(v_timeout), 64'h0);
    check("t5_resp", 64'(v_resp), 64'h2);
    check("t5_rdata_zero", 64'(v_rdata), 64'h0);
    check("t5_err_count", 64'(v_err), 64'h1);
    check("t5_wr_count", 64'(v_wr), 64'h3);
    check("t5_rsp_stable", 64'(unstable), 64'h0);
    check("t5_cmd_ready_busy", 64'(cmd_ready_hi), 64'h0);

    // Reset asserted mid-read in RD_DATA
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 32'h40;
    tick();
    i_cmd_valid = 1'b0;
    m.arready = 1'b1;
    tick();
    m.arready = 1'b0;
    check("t6_in_rd_data", 64'(m.rready), 64'h1);
    #2 rst_main_n = 1'b0;
    #1 check("t6_async_reset_zero", 64'(|all_out), 64'h0);
    tick(); tick();
    rst_main_n = 1'b1;
    check("t6_cmd_ready_at_release", 64'(o_cmd_ready), 64'h0);
    tick();
    check("t6_cmd_ready_after_release", 64'(o_cmd_ready), 64'h1);
    check("t6_counters_zero", 64'({o_wr_count, o_rd_count} | 64'(o_err_count)), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI-Lite initiator that turns a simple command/response stream into AXI-Lite reads and writes.
- Drives the same OCL-style slave port the shell uses. Sequencers and self-test logic on clk_main_a0 use it to program Ising weights and read spin results without host involvement.
- Handles one transaction at a time, with registered outputs, a per-transaction timeout flag and traffic counters.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (strobe width is DATA_W/8).
- TIMEOUT, 1024, cycles a phase may wait for a handshake before timeout_flag sets; must be >=1.

Ports:
- clk_main_a0  in  1  clock.
- rst_main_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- cmd_wstrb  in  DATA_W/8  write strobes (ignored for reads).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP.
- rsp_timeout  out  1  a phase of this transaction exceeded TIMEOUT.
- m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  write data channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read address channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  read data channel.
- wr_count, rd_count  out  32  completed write and read transactions; wrap at 2^32.
- err_count  out  16  completed transactions with resp != 0; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All valids, bready, rready and rsp_valid are 0; cmd_ready is 0.
  - All counters, addr/data registers and rsp_* are 0.
  - The FSM is in IDLE.
  - Asserting reset mid-transaction abandons it immediately; this is the only legal abandonment.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1 (registered, so it is 1 the cycle after reset release).
  - On accept, capture the cmd_* fields. Write goes to WR, read goes to RD_ADDR.
  - cmd_ready drops the cycle after accept.
- WR:
  - awvalid and wvalid both assert the cycle after accept.
  - Each valid drops the cycle after its own handshake. The two handshakes may complete in either order or in the same cycle.
  - Once both are done, go to WR_RESP.
  - awaddr/wdata/wstrb stay stable while the corresponding valid is high.
- WR_RESP:
  - bready=1. On bvalid, capture bresp and go to RSP.
  - bready is 0 in every other state.
- RD_ADDR: arvalid=1. On arready, go to RD_DATA.
- RD_DATA:
  - rready=1. On rvalid, capture rdata/rresp and go to RSP.
  - rready is 0 in every other state.
- RSP:
  - rsp_valid=1 with rsp_* held stable. On rsp_ready, go to IDLE.
  - The counters update in the cycle rsp_valid first asserts.
  - With rsp_ready tied high, a new command is accepted 1 cycle after the response handshake.
- Latency: minimum command-accept to rsp_valid is 4 cycles for a read (arready and rvalid each high on first opportunity) and 4 cycles for a write (awready/wready immediate, bvalid next cycle).
- AXI rules:
  - A valid, once asserted, is never deasserted before its ready.
  - Valids never depend combinationally on readies.
  - Only one transaction is outstanding at any time.
- Timeout:
  - A phase counter clears on entering WR, WR_RESP, RD_ADDR or RD_DATA, and increments each cycle in those states.
  - At count == TIMEOUT the per-transaction flag sets. The transaction still waits, so AXI stays legal.
  - The flag is reported on rsp_timeout and clears on the next command accept.
- Counter overflow: wr_count and rd_count wrap to 0; err_count holds at 16'hFFFF.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, slave ready immediately, bresp=0 -> AW/W beats carry those values; rsp_valid 4 cycles after accept; rsp_resp=0; wr_count=1; err_count=0.
- Read addr 0x24, slave returns rdata 0x0000_0031 with rresp=0 after 3 wait cycles -> rsp_rdata=0x31; rsp_write=0; rd_count=1; arvalid held through all wait cycles.
- Write where wready comes 5 cycles before awready -> wvalid drops after its beat, awvalid stays high; exactly one B accepted; bready never high before both beats.
- TIMEOUT=8, read whose rvalid is delayed 20 cycles -> rsp_timeout=1 and rsp_resp=rresp; next command's response has rsp_timeout=0.
- Slave returns bresp=2'b10, with rsp_ready held low for 10 cycles -> rsp_* stable while waiting; err_count=1; cmd_ready=0 until the response handshake, then 1 the next cycle.
- Assert rst_main_n low during RD_DATA -> all outputs 0 asynchronously; after release cmd_ready=1 next cycle and counters read 0.
